// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM states and the default datapath width.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } md_state_t;

endpackage

// File: rtl/mult_div_iter.sv
// Iterative unsigned datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per asserted 'step'. Works on magnitudes only.
module mult_div_iter import mips_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] m;
  logic             div_mode;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shl  = {acc, q[WIDTH-1]};
    // One extra bit so diff[WIDTH+1] is a clean borrow flag.
    diff = {1'b0, shl} - {2'b00, m};
  end

  // Multiply: {acc,q} is the product shift register, q starts as the multiplier.
  // Divide: acc is the partial remainder, q shifts dividend out and quotient in.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      q        <= is_div ? a_in : b_in;
      m        <= is_div ? b_in : a_in;
      div_mode <= is_div;
    end else if (step) begin
      if (div_mode) begin
        if (!diff[WIDTH+1]) begin
          acc <= diff[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shl[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= sum[WIDTH:1];
        q   <= {sum[0], q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/unidade_mult_div.sv
// MIPS HI/LO multiply/divide unit: control FSM, operand sign handling and the
// architectural HI/LO registers around the iterative datapath.
module unidade_mult_div import mips_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, is_signed, rs_neg, rt_neg, div_zero;
  logic [WIDTH-1:0]   rs_raw;
  logic               op_iter, op_signed, op_div, accept, step;
  logic [WIDTH-1:0]   mag_a, mag_b, acc, q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_iter   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    op_div    = (op == OP_DIV) || (op == OP_DIVU);
    mag_a     = (op_signed && rsData[WIDTH-1]) ? -rsData : rsData;
    mag_b     = (op_signed && rtData[WIDTH-1]) ? -rtData : rtData;
    accept    = (state == S_IDLE) && start && op_iter;
  end

  // FINISH spans two cycles: the first commits HI/LO, the second shows done.
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ITER;
      S_ITER: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = S_FINISH;
      end
      S_FINISH: if (done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    prod_fix = (is_signed && (rs_neg ^ rt_neg)) ? -{acc, q} : {acc, q};
    quo_fix  = (is_signed && (rs_neg ^ rt_neg)) ? -q : q;
    rem_fix  = (is_signed && rs_neg) ? -acc : acc;
  end

  mult_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .is_div (op_div),
    .a_in   (mag_a),
    .b_in   (mag_b),
    .acc    (acc),
    .q      (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      rs_neg    <= 1'b0;
      rt_neg    <= 1'b0;
      div_zero  <= 1'b0;
      rs_raw    <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_FINISH) && !done;
      if (accept) begin
        cnt       <= '0;
        is_div    <= op_div;
        is_signed <= op_signed;
        rs_neg    <= rsData[WIDTH-1];
        rt_neg    <= rtData[WIDTH-1];
        div_zero  <= op_div && (rtData == '0);
        rs_raw    <= rsData;
      end else if (state == S_ITER) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_IDLE && start && op == OP_MTHI) hi <= rsData;
      if (state == S_IDLE && start && op == OP_MTLO) lo <= rsData;
      if (state == S_FINISH && !done) begin
        if (is_div && div_zero) begin
          hi <= rs_raw;
          lo <= '1;
        end else if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule
